instr_fetch_responder: RTL and testbench

Responder side of the fetch interface. The program counter issues word addresses. This block returns the 32-bit instruction stored at each address after a fixed read latency. It buffers responses so the decode stage can stall, and supports a flush for taken branches or jumps. It also owns the instruction store, which is loaded through a separate write port (loader/testbench).

---
 rtl/fetch_pkg.sv | 15 +
 rtl/rsp_fifo.sv | 59 +++++
 rtl/instr_fetch_responder.sv | 119 +++++++++++
 tb/tb_instr_fetch_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch responder.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
    logic               err;
  } fetch_rsp_t;

endpackage

// File: rtl/rsp_fifo.sv
// Circular response buffer; flush empties it, head entry drives the outputs.
module rsp_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  fetch_rsp_t                 i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic                       o_valid,
  output fetch_rsp_t                 o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  fetch_rsp_t      r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_next(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_next(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_responder.sv
// Instruction store plus fixed-latency read pipeline feeding a credit-protected response buffer.
module instr_fetch_responder
  import fetch_pkg::*;
#(
  parameter int                 DEPTH     = 1024,
  parameter int                 LATENCY   = 2,
  parameter int                 BUF_DEPTH = 2,
  parameter logic [INSTR_W-1:0] NOP_WORD  = NOP_WORD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [INSTR_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0]  rsp_addr,
  output logic               rsp_err,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(BUF_DEPTH+1);
  localparam int CW = $clog2(LATENCY+BUF_DEPTH+1);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [INSTR_W-1:0] r_rd_data;
  logic [ADDR_W-1:0]  r_s0_addr;
  logic               r_s0_err;
  logic [LATENCY-1:0] r_vld;

  logic               w_req_in_range;
  logic               w_wr_in_range;
  logic               w_accept;
  logic [CW-1:0]      w_inflight;
  logic [CW-1:0]      w_used;
  logic [OW-1:0]      w_occ;
  fetch_rsp_t         w_s0;
  fetch_rsp_t         w_tail;
  fetch_rsp_t         w_head;

  assign w_req_in_range = (req_addr < DEPTH_A);
  assign w_wr_in_range  = (wr_addr < DEPTH_A);

  // Credits cover every in-flight entry, so the buffer can always absorb the pipeline.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      if (r_vld[i]) w_inflight = w_inflight + CW'(1);
    end
  end

  assign w_used    = w_inflight + CW'(w_occ);
  assign req_ready = rst_n && !flush && (w_used < CW'(BUF_DEPTH));
  assign w_accept  = req_valid && req_ready;

  // Read and write share the edge; the read sees the word from before the write.
  always_ff @(posedge clk) begin
    if (wr_en && w_wr_in_range) r_mem[wr_addr[AW-1:0]] <= wr_data;
    if (w_accept) begin
      r_rd_data <= r_mem[req_addr[AW-1:0]];
      r_s0_addr <= req_addr;
      r_s0_err  <= !w_req_in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_accept;
      for (int i = 1; i < LATENCY; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  always_comb begin
    w_s0       = '0;
    w_s0.addr  = r_s0_addr;
    w_s0.instr = r_s0_err ? NOP_WORD : r_rd_data;
    w_s0.err   = r_s0_err;
  end

  if (LATENCY == 1) begin : g_lat1
    assign w_tail = w_s0;
  end else begin : g_latn
    fetch_rsp_t r_pipe [LATENCY-1];

    always_ff @(posedge clk) begin
      r_pipe[0] <= w_s0;
      for (int i = 1; i < LATENCY-1; i++) r_pipe[i] <= r_pipe[i-1];
    end

    assign w_tail = r_pipe[LATENCY-2];
  end

  rsp_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_vld[LATENCY-1]),
    .i_data  (w_tail),
    .i_pop   (rsp_ready),
    .i_flush (flush),
    .o_valid (rsp_valid),
    .o_data  (w_head),
    .o_count (w_occ)
  );

  assign rsp_instr = w_head.instr;
  assign rsp_addr  = w_head.addr;
  assign rsp_err   = w_head.err;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed bench for instr_fetch_responder at DEPTH=1024, LATENCY=2, BUF_DEPTH=2.
module tb_instr_fetch_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_err;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_fetch_responder #(
    .DEPTH     (1024),
    .LATENCY   (LAT),
    .BUF_DEPTH (2),
    .NOP_WORD  (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Single fetch from idle; optional write issued in the same cycle as the request.
  task automatic fetch(input logic [31:0] a, input logic [31:0] exp_i, input logic exp_e,
                       input bit do_wr, input logic [31:0] wa, input logic [31:0] wd,
                       input string tag);
    int seen_k;
    seen_k = -1;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = a;
    if (do_wr) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
    @(negedge clk);
    chk({tag, "_rdy"}, req_ready, 1);
    step();
    req_valid = 1'b0; wr_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid && seen_k < 0) begin
        seen_k = k;
        chk({tag, "_addr"}, rsp_addr, a);
        chk({tag, "_instr"}, rsp_instr, exp_i);
        chk({tag, "_err"}, rsp_err, exp_e);
      end
      step();
    end
    chk({tag, "_lat"}, seen_k, LAT);
  endtask

  int exp_acc [4] = '{0, 1, 4, 5};
  int exp_rsp [4] = '{3, 4, 7, 8};
  int n_acc, n_rsp;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    rst_n = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_instr", rsp_instr, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    chk("rst_req_ready", req_ready, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", req_ready, 1);
    step();

    for (int a = 0; a < 16; a++) wr(32'(a), 32'hA000_0000 + 32'(a));
    wr(32'd976, 32'h1234_5678);

    // 1: continuous requests 0..3; credits allow accepts in cycles 0,1,4,5
    rsp_ready = 1'b1; n_acc = 0; n_rsp = 0;
    for (int c = 0; c < 12; c++) begin
      req_valid = (n_acc < 4); req_addr = 32'(n_acc);
      @(negedge clk);
      if (rsp_valid) begin
        if (n_rsp < 4) begin
          chk("t1_rsp_addr", rsp_addr, 32'(n_rsp));
          chk("t1_rsp_instr", rsp_instr, 32'hA000_0000 + 32'(n_rsp));
          chk("t1_rsp_err", rsp_err, 0);
          chk("t1_rsp_cyc", 32'(c), 32'(exp_rsp[n_rsp]));
        end
        n_rsp++;
      end
      if (req_valid && req_ready) begin
        chk("t1_acc_cyc", 32'(c), 32'(exp_acc[n_acc]));
        n_acc++;
      end
      step();
    end
    req_valid = 1'b0;
    chk("t1_n_acc", n_acc, 4);
    chk("t1_n_rsp", n_rsp, 4);

    // 2: stalled decode limits acceptance to BUF_DEPTH
    rsp_ready = 1'b0; n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1; req_addr = 32'd10 + 32'(n_acc);
      @(negedge clk);
      if (req_ready) n_acc++;
      step();
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("t2_n_acc", n_acc, 2);
    chk("t2_req_ready", req_ready, 0);
    chk("t2_head_addr", rsp_addr, 32'd10);
    step();
    rsp_ready = 1'b1; n_rsp = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        chk("t2_drain_addr", rsp_addr, 32'd10 + 32'(n_rsp));
        chk("t2_drain_instr", rsp_instr, 32'hA000_000A + 32'(n_rsp));
        n_rsp++;
      end
      step();
    end
    chk("t2_n_rsp", n_rsp, 2);
    @(negedge clk);
    chk("t2_ready_back", req_ready, 1);
    step();

    // 3: out of range
    fetch(32'd1024, 32'h0, 1'b1, 1'b0, 0, 0, "t3_1024");
    fetch(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 0, 0, "t3_max");

    // 4: flush drops 5 and 6, blocks 7 for one cycle
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'd5;
    @(negedge clk); chk("t4_acc5", req_ready, 1); step();
    req_addr = 32'd6;
    @(negedge clk); chk("t4_acc6", req_ready, 1); step();
    req_addr = 32'd7; flush = 1'b1;
    @(negedge clk); chk("t4_flush_rdy", req_ready, 0); step();
    flush = 1'b0;
    @(negedge clk);
    chk("t4_post_valid", rsp_valid, 0);
    chk("t4_post_rdy", req_ready, 1);
    step();
    req_valid = 1'b0; n_rsp = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (n_rsp == 0) begin
          chk("t4_rsp_addr", rsp_addr, 32'd7);
          chk("t4_rsp_instr", rsp_instr, 32'hA000_0007);
        end
        n_rsp++;
      end
      step();
    end
    chk("t4_n_rsp", n_rsp, 1);

    // 5: write port
    fetch(32'd8, 32'hA000_0008, 1'b0, 1'b1, 32'd8, 32'hDEAD_BEEF, "t5_old");
    fetch(32'd8, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 0, "t5_new");
    wr(32'd2000, 32'hCAFE_F00D);
    fetch(32'd976, 32'h1234_5678, 1'b0, 1'b0, 0, 0, "t5_alias");
    fetch(32'd2000, 32'h0, 1'b1, 1'b0, 0, 0, "t5_oor");
    fetch(32'd9, 32'hA000_0009, 1'b0, 1'b0, 0, 0, "t5_other");

    // 6: reset with one buffered and one in flight
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'd12; step();
    req_addr = 32'd13; step();
    req_valid = 1'b0; step();
    rst_n = 1'b0; req_valid = 1'b1; req_addr = 32'd14;
    @(negedge clk);
    chk("t6_pre_valid", rsp_valid, 1);
    chk("t6_rst_rdy", req_ready, 0);
    step();
    rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("t6_valid", rsp_valid, 0);
    chk("t6_rdy", req_ready, 1);
    chk("t6_instr", rsp_instr, 0);
    chk("t6_addr", rsp_addr, 0);
    n_rsp = 0;
    for (int c = 0; c < 2*LAT; c++) begin
      step();
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    chk("t6_stale", n_rsp, 0);
    step();
    fetch(32'd3, 32'hA000_0003, 1'b0, 1'b0, 0, 0, "t6_after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
